// File: rtl/funct_generator_pkg.sv
// rtl/funct_generator_pkg.sv - shared types, limits and saturation-bound helpers for the multiply/accumulate datapath
package funct_generator_pkg;

    typedef struct packed {
        logic sgn;
        logic acc;
    } fg_mul_tag_t;

    localparam int MAX_PIPE_STAGES = 8;
    localparam int MAX_OUT_WIDTH   = 128;

    // Largest representable value of a width-bit result, signed or unsigned.
    function automatic logic [MAX_OUT_WIDTH-1:0] sat_max(input logic sgn, input int width);
        logic [MAX_OUT_WIDTH-1:0] one;
        one = {{(MAX_OUT_WIDTH-1){1'b0}}, 1'b1};
        if (sgn) begin
            return (one << (width - 1)) - one;
        end
        return (width >= MAX_OUT_WIDTH) ? '1 : (one << width) - one;
    endfunction

    // Most negative two's-complement value of a width-bit result, in the low width bits.
    function automatic logic [MAX_OUT_WIDTH-1:0] sat_min_signed(input int width);
        logic [MAX_OUT_WIDTH-1:0] one;
        one = {{(MAX_OUT_WIDTH-1){1'b0}}, 1'b1};
        return one << (width - 1);
    endfunction

endpackage

// File: rtl/funct_generator_acc_sat.sv
// rtl/funct_generator_acc_sat.sv - final stage: accumulate adder, overflow detect, optional clamp, output and acc_q registers
// Optional feature macro: FUNCT_GEN_MULTI_SAT_EN
module funct_generator_acc_sat
    import funct_generator_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] prod,
    input  fg_mul_tag_t      tag,
    output logic [WIDTH-1:0] data,
    output logic             ovf,
    output logic             valid
);

`ifdef FUNCT_GEN_MULTI_SAT_EN
    localparam logic [MAX_OUT_WIDTH-1:0] SMAX_W = sat_max(1'b1, WIDTH);
    localparam logic [MAX_OUT_WIDTH-1:0] UMAX_W = sat_max(1'b0, WIDTH);
    localparam logic [MAX_OUT_WIDTH-1:0] SMIN_W = sat_min_signed(WIDTH);
    localparam logic [WIDTH-1:0] SMAX = SMAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] UMAX = UMAX_W[WIDTH-1:0];
    localparam logic [WIDTH-1:0] SMIN = SMIN_W[WIDTH-1:0];
`endif

    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             sovf;
    logic             ovf_c;

    always_comb begin
        {carry, sum} = {1'b0, acc_q} + {1'b0, prod};
        sovf   = (acc_q[WIDTH-1] == prod[WIDTH-1]) && (sum[WIDTH-1] != acc_q[WIDTH-1]);
        ovf_c  = tag.acc && (tag.sgn ? sovf : carry);
        result = tag.acc ? sum : prod;
`ifdef FUNCT_GEN_MULTI_SAT_EN
        // A signed overflow can only happen with both addends of one sign, so acc_q picks the rail.
        if (ovf_c) begin
            result = !tag.sgn ? UMAX : (acc_q[WIDTH-1] ? SMIN : SMAX);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            data  <= '0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else if (en) begin
            valid <= in_valid;
            if (in_valid) begin
                acc_q <= result;
                data  <= result;
                ovf   <= ovf_c;
            end
        end
    end

endmodule

// File: rtl/funct_generator_multi_pipe.sv
// rtl/funct_generator_multi_pipe.sv - pipelined signed/unsigned multiply-accumulate with valid/ready handshake
// Optional feature macro: FUNCT_GEN_MULTI_SAT_EN (saturating accumulate)
module funct_generator_multi_pipe
    import funct_generator_pkg::*;
#(
    parameter  int DATA_WIDTH     = 32,
    parameter  int PIPE_STAGES    = 3,
    localparam int DATA_WIDTH_OUT = 2 * DATA_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [DATA_WIDTH-1:0]     a_i,
    input  logic [DATA_WIDTH-1:0]     b_i,
    input  logic                      signed_i,
    input  logic                      acc_i,
    output logic [DATA_WIDTH_OUT-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      ovf_o
);

    logic                      advance;
    logic [DATA_WIDTH_OUT-1:0] ax;
    logic [DATA_WIDTH_OUT-1:0] bx;
    logic [DATA_WIDTH_OUT-1:0] prod;
    fg_mul_tag_t               tag_in;
    logic [DATA_WIDTH_OUT-1:0] fin_prod;
    fg_mul_tag_t               fin_tag;
    logic                      fin_vld;

    // The pipeline moves as a single unit; any downstream stall freezes every stage.
    assign ready_o = !valid_o || ready_i;
    assign advance = ready_o;

    // Extending both operands to the full output width makes the low half of one
    // plain multiply correct for signed and unsigned operands alike.
    always_comb begin
        ax     = {{DATA_WIDTH{signed_i & a_i[DATA_WIDTH-1]}}, a_i};
        bx     = {{DATA_WIDTH{signed_i & b_i[DATA_WIDTH-1]}}, b_i};
        prod   = ax * bx;
        tag_in = '{sgn: signed_i, acc: acc_i};
    end

    generate
        if (PIPE_STAGES > 1) begin : g_pipe
            logic [DATA_WIDTH_OUT-1:0] prod_q [PIPE_STAGES-1];
            fg_mul_tag_t               tag_q  [PIPE_STAGES-1];
            logic                      vld_q  [PIPE_STAGES-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE_STAGES - 1; i++) begin
                        vld_q[i] <= 1'b0;
                    end
                end else if (advance) begin
                    vld_q[0] <= valid_i;
                    for (int i = 1; i < PIPE_STAGES - 1; i++) begin
                        vld_q[i] <= vld_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (advance) begin
                    prod_q[0] <= prod;
                    tag_q[0]  <= tag_in;
                    for (int i = 1; i < PIPE_STAGES - 1; i++) begin
                        prod_q[i] <= prod_q[i-1];
                        tag_q[i]  <= tag_q[i-1];
                    end
                end
            end

            assign fin_prod = prod_q[PIPE_STAGES-2];
            assign fin_tag  = tag_q[PIPE_STAGES-2];
            assign fin_vld  = vld_q[PIPE_STAGES-2];
        end else begin : g_nopipe
            assign fin_prod = prod;
            assign fin_tag  = tag_in;
            assign fin_vld  = valid_i;
        end
    endgenerate

    funct_generator_acc_sat #(
        .WIDTH (DATA_WIDTH_OUT)
    ) u_acc_sat (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (advance),
        .in_valid (fin_vld),
        .prod     (fin_prod),
        .tag      (fin_tag),
        .data     (data_o),
        .ovf      (ovf_o),
        .valid    (valid_o)
    );

endmodule

// File: tb/tb_funct_generator_multi_pipe.sv
// tb/tb_funct_generator_multi_pipe.sv - self-checking bench: directed vector table, stall/reset sequences, randomized traffic vs reference model
module tb_funct_generator_multi_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [7:0]  a_i;
    logic [7:0]  b_i;
    logic        signed_i;
    logic        acc_i;
    logic [15:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        ovf_o;

    funct_generator_multi_pipe #(
        .DATA_WIDTH  (8),
        .PIPE_STAGES (3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .a_i      (a_i),
        .b_i      (b_i),
        .signed_i (signed_i),
        .acc_i    (acc_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        sgn;
        logic        acc;
        logic [15:0] d;
        logic        o;
    } vec_t;

    typedef struct {
        logic [15:0] md;
        logic        mo;
        logic        ht;
        logic [15:0] td;
        logic        tov;
    } exp_t;

    vec_t        tab [12];
    exp_t        expq [$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          acc_cnt = 0;
    logic [15:0] acc_m;
    logic        tab_ht;
    logic [15:0] tab_d;
    logic        tab_o;
    logic        prev_stall;
    logic [15:0] prev_d;
    logic        prev_o;
    logic        done;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference: integer arithmetic on the operand values, range checks for overflow.
    task automatic model(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ac,
                         output logic [15:0] d, output logic o);
        longint pa, pb, av, sum;
        pa  = s ? longint'($signed(a)) : longint'(a);
        pb  = s ? longint'($signed(b)) : longint'(b);
        av  = s ? longint'($signed(acc_m)) : longint'(acc_m);
        sum = ac ? av + pa * pb : pa * pb;
        o   = ac && (s ? (sum > 32767 || sum < -32768) : (sum > 65535));
        d   = sum[15:0];
`ifdef FUNCT_GEN_MULTI_SAT_EN
        if (o) d = s ? ((sum > 0) ? 16'h7FFF : 16'h8000) : 16'hFFFF;
`endif
        acc_m = d;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic s, input logic ac,
                        input logic ht, input logic [15:0] td, input logic tov);
        int start;
        bit got;
        a_i = a; b_i = b; signed_i = s; acc_i = ac; valid_i = 1'b1;
        tab_ht = ht; tab_d = td; tab_o = tov;
        start = acc_cnt;
        got = 0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge clk); #1;
            if (acc_cnt != start) got = 1;
        end
        if (!got) begin
            n_cmp++; n_err++;
            $display("FAIL send_timeout: transaction not accepted within 200 cycles");
        end
    endtask

    task automatic send_vec(input int i);
        send(tab[i].a, tab[i].b, tab[i].sgn, tab[i].acc, 1'b1, tab[i].d, tab[i].o);
    endtask

    task automatic idle();
        valid_i = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && expq.size() != 0; k++) begin
            @(posedge clk); #1;
        end
        if (expq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL drain: %0d results still outstanding, expected 0", expq.size());
        end
    endtask

    initial begin
        tab[0]  = '{8'hFD, 8'h05, 1'b1, 1'b0, 16'hFFF1, 1'b0};
        tab[1]  = '{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01, 1'b0};
        tab[2]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 16'h0001, 1'b0};
        tab[3]  = '{8'h7F, 8'h7F, 1'b1, 1'b0, 16'h3F01, 1'b0};
        tab[4]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h7E02, 1'b0};
`ifdef FUNCT_GEN_MULTI_SAT_EN
        tab[5]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h7FFF, 1'b1};
        tab[9]  = '{8'h10, 8'h10, 1'b0, 1'b1, 16'hFFFF, 1'b1};
`else
        tab[5]  = '{8'h7F, 8'h7F, 1'b1, 1'b1, 16'hBD03, 1'b1};
        tab[9]  = '{8'h10, 8'h10, 1'b0, 1'b1, 16'h0000, 1'b1};
`endif
        tab[6]  = '{8'h01, 8'h02, 1'b0, 1'b0, 16'h0002, 1'b0};
        tab[7]  = '{8'h03, 8'h04, 1'b0, 1'b1, 16'h000E, 1'b0};
        tab[8]  = '{8'h80, 8'h02, 1'b1, 1'b0, 16'hFF00, 1'b0};
        tab[10] = '{8'h05, 8'h05, 1'b1, 1'b0, 16'h0019, 1'b0};
        tab[11] = '{8'hFF, 8'h02, 1'b1, 1'b1, 16'h0017, 1'b0};

        rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
        a_i = '0; b_i = '0; signed_i = 1'b0; acc_i = 1'b0;
        acc_m = '0; prev_stall = 1'b0; prev_d = '0; prev_o = 1'b0;
        tab_ht = 1'b0; tab_d = '0; tab_o = 1'b0; done = 1'b0;

        // Output monitor: scoreboard pop on consume, model push on accept, hold check on stall.
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    expq.delete();
                    acc_m = '0;
                    prev_stall = 1'b0;
                end else begin
                    if (prev_stall) begin
                        chk("stall_valid_hold", 32'(valid_o), 32'd1);
                        chk("stall_data_hold", 32'(data_o), 32'(prev_d));
                        chk("stall_ovf_hold", 32'(ovf_o), 32'(prev_o));
                    end
                    if (valid_o && ready_i) begin
                        if (expq.size() == 0) begin
                            n_cmp++; n_err++;
                            $display("FAIL unexpected_result: got 0x%0h, expected no result", data_o);
                        end else begin
                            exp_t e;
                            e = expq.pop_front();
                            chk("data_model", 32'(data_o), 32'(e.md));
                            chk("ovf_model", 32'(ovf_o), 32'(e.mo));
                            if (e.ht) begin
                                chk("data_table", 32'(data_o), 32'(e.td));
                                chk("ovf_table", 32'(ovf_o), 32'(e.tov));
                            end
                        end
                    end
                    if (valid_i && ready_o) begin
                        exp_t e;
                        model(a_i, b_i, signed_i, acc_i, e.md, e.mo);
                        e.ht = tab_ht; e.td = tab_d; e.tov = tab_o;
                        expq.push_back(e);
                        acc_cnt++;
                    end
                    prev_stall = valid_o && !ready_i;
                    prev_d = data_o;
                    prev_o = ovf_o;
                end
            end
        join_none

        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        chk("reset_valid_o", 32'(valid_o), 32'd0);
        chk("reset_data_o", 32'(data_o), 32'd0);
        chk("reset_ovf_o", 32'(ovf_o), 32'd0);
        chk("reset_ready_o", 32'(ready_o), 32'd1);

        send_vec(0);
        valid_i = 1'b0;
        @(posedge clk); #1;
        chk("latency_not_early", 32'(valid_o), 32'd0);
        @(posedge clk); #1;
        chk("latency_valid", 32'(valid_o), 32'd1);
        idle();
        drain();

        for (int i = 1; i <= 5; i++) send_vec(i);
        idle();
        drain();

        fork
            begin
                for (int i = 6; i <= 11; i++) send_vec(i);
                idle();
            end
            begin
                logic [15:0] snap;
                repeat (3) @(posedge clk);
                #1 ready_i = 1'b0;
                snap = '0;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_ready_low", 32'(ready_o), 32'd0);
                    chk("bp_valid_high", 32'(valid_o), 32'd1);
                    if (k == 0) snap = data_o;
                    else chk("bp_data_stable", 32'(data_o), 32'(snap));
                end
                @(posedge clk); #1 ready_i = 1'b1;
            end
        join
        drain();

        send(8'h11, 8'h11, 1'b0, 1'b0, 1'b0, '0, 1'b0);
        send(8'h22, 8'h03, 1'b0, 1'b1, 1'b0, '0, 1'b0);
        rst_n = 1'b0; valid_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_valid_after_reset", 32'(valid_o), 32'd0);
        end
        @(posedge clk); #1;
        send(8'h02, 8'h03, 1'b1, 1'b1, 1'b1, 16'h0006, 1'b0);
        idle();
        drain();

        fork
            begin
                for (int n = 0; n < 300; n++) begin
                    logic [7:0] ra, rb;
                    ra = 8'($urandom_range(0, 255));
                    rb = 8'($urandom_range(0, 255));
                    if ($urandom_range(0, 3) == 0) ra = ($urandom_range(0, 1) == 0) ? 8'h7F : 8'h80;
                    if ($urandom_range(0, 4) == 0) idle();
                    send(ra, rb, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), 1'b0, '0, 1'b0);
                end
                idle();
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    ready_i = ($urandom_range(0, 2) != 0);
                end
                ready_i = 1'b1;
            end
        join
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
